// File: rtl/common.sv
// Shared pipeline types: thread ids, machine words, virtual and physical pointers.
package common;

  localparam int unsigned n_threads = 4;

  typedef logic [1:0]  threadid_t;
  typedef logic [31:0] word_t;
  typedef logic [31:0] vptr_t;
  typedef logic [19:0] pptr_t;
  typedef logic [4:0]  regid_t;

  typedef enum logic [1:0] {
    TlbNone,
    TlbItlb,
    TlbDtlb
  } tlbwrite_t;

endpackage

// File: rtl/store_buffer.sv
// Store buffer FIFO: pushes committed stores, presents the head until the memory port takes it.
module store_buffer
  import common::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  logic  isbyte_i,
  input  pptr_t addr_i,
  input  word_t data_i,
  input  logic  ready_i,
  output logic  valid_o,
  output logic  isbyte_o,
  output pptr_t addr_o,
  output word_t data_o,
  output logic  full_o
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);

  logic [PtrW-1:0]     head_q, tail_q;
  logic [PtrW:0]       count_q, count_d;
  logic [SB_DEPTH-1:0] isbyte_q;
  pptr_t               addr_q [SB_DEPTH];
  word_t               data_q [SB_DEPTH];
  logic                do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(SB_DEPTH));
  assign valid_o = (count_q != '0);

  // Head is gated so the port reads zero while empty instead of stale entries.
  assign isbyte_o = valid_o ? isbyte_q[head_q] : 1'b0;
  assign addr_o   = valid_o ? addr_q[head_q]   : '0;
  assign data_o   = valid_o ? data_q[head_q]   : '0;

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = valid_o && ready_i;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      isbyte_q[tail_q] <= isbyte_i;
      addr_q[tail_q]   <= addr_i;
      data_q[tail_q]   <= data_i;
    end
  end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: in-order commit per thread, register writeback, redirects and store buffering.
module stage_wb
  import common::*;
#(
  parameter int unsigned SB_DEPTH = 4,
  parameter vptr_t       RESET_PC = 32'h1000
) (
  input  logic      clk,
  input  logic      rst,
  input  threadid_t tl_thread,
  input  logic      tl_isvalid,
  input  regid_t    tl_dst,
  input  vptr_t     tl_pc,
  input  word_t     tl_r2,
  input  word_t     tl_data,
  input  logic      tl_isequal,
  input  word_t     tl_mul,
  input  logic      tl_flag_reg,
  input  logic      tl_flag_mul,
  input  logic      tl_flag_jump,
  input  logic      tl_flag_branch,
  input  logic      tl_flag_store,
  input  logic      tl_flag_isbyte,
  input  logic      tl_flag_iret,
  input  tlbwrite_t tl_flag_tlbwrite,
  output logic      rf_wen,
  output threadid_t rf_thread,
  output regid_t    rf_dst,
  output word_t     rf_wdata,
  output logic      redirect_en,
  output threadid_t redirect_thread,
  output vptr_t     redirect_pc,
  output logic      store_en,
  output logic      store_isbyte,
  output pptr_t     store_addr,
  output word_t     store_data,
  input  logic      store_ready,
  output logic      sb_full
);

  vptr_t waiting_pc_q [n_threads];
  logic  in_order, commit, retry, taken, sb_push;
  vptr_t next_pc;

  // iret and tlbwrite are reserved and commit like ordinary instructions.
  logic unused_reserved;
  assign unused_reserved = ^{tl_flag_iret, tl_flag_tlbwrite};

  always_comb begin
    in_order = (tl_pc == waiting_pc_q[tl_thread]);
    commit   = in_order && tl_isvalid && !(tl_flag_store && sb_full);
    retry    = in_order && !commit;
    taken    = tl_flag_jump && (!tl_flag_branch || tl_isequal);
    next_pc  = taken ? tl_data : tl_pc + 32'd4;
    sb_push  = commit && tl_flag_store;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < int'(n_threads); t++) waiting_pc_q[t] <= RESET_PC;
      rf_wen          <= 1'b0;
      rf_thread       <= '0;
      rf_dst          <= '0;
      rf_wdata        <= '0;
      redirect_en     <= 1'b0;
      redirect_thread <= '0;
      redirect_pc     <= '0;
    end else begin
      rf_wen      <= commit && tl_flag_reg;
      redirect_en <= (commit && taken) || retry;
      if (commit) waiting_pc_q[tl_thread] <= next_pc;
      if (commit && tl_flag_reg) begin
        rf_thread <= tl_thread;
        rf_dst    <= tl_dst;
        rf_wdata  <= tl_flag_mul ? tl_mul : tl_data;
      end
      if ((commit && taken) || retry) begin
        redirect_thread <= tl_thread;
        redirect_pc     <= commit ? tl_data : waiting_pc_q[tl_thread];
      end
    end
  end

  store_buffer #(
    .SB_DEPTH(SB_DEPTH)
  ) u_store_buffer (
    .clk_i    (clk),
    .rst_i    (rst),
    .push_i   (sb_push),
    .isbyte_i (tl_flag_isbyte),
    .addr_i   (tl_data[19:0]),
    .data_i   (tl_r2),
    .ready_i  (store_ready),
    .valid_o  (store_en),
    .isbyte_o (store_isbyte),
    .addr_o   (store_addr),
    .data_o   (store_data),
    .full_o   (sb_full)
  );

endmodule

// File: tb/tb_stage_wb.sv
// Directed bench for stage_wb: commit, jumps, retries, store buffer fill/drain and reset.
module tb_stage_wb;
  import common::*;

  localparam logic [5:0] F_REG  = 6'd1;
  localparam logic [5:0] F_MUL  = 6'd2;
  localparam logic [5:0] F_JMP  = 6'd4;
  localparam logic [5:0] F_BR   = 6'd8;
  localparam logic [5:0] F_ST   = 6'd16;
  localparam logic [5:0] F_BYTE = 6'd32;
  localparam vptr_t IDLE_PC = 32'hDEAD_BEE0;

  logic      clk = 1'b0;
  logic      rst;
  threadid_t tl_thread;
  logic      tl_isvalid;
  regid_t    tl_dst;
  vptr_t     tl_pc;
  word_t     tl_r2, tl_data, tl_mul;
  logic      tl_isequal;
  logic      tl_flag_reg, tl_flag_mul, tl_flag_jump, tl_flag_branch;
  logic      tl_flag_store, tl_flag_isbyte, tl_flag_iret;
  tlbwrite_t tl_flag_tlbwrite;
  logic      rf_wen, redirect_en, store_en, store_isbyte, store_ready, sb_full;
  threadid_t rf_thread, redirect_thread;
  regid_t    rf_dst;
  word_t     rf_wdata, store_data;
  vptr_t     redirect_pc;
  pptr_t     store_addr;

  int n_checks = 0;
  int n_fails  = 0;

  word_t exp_data [4];
  word_t exp_r2   [4];

  always #5 clk = ~clk;

  stage_wb #(
    .SB_DEPTH(4),
    .RESET_PC(32'h1000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tl_thread        (tl_thread),
    .tl_isvalid       (tl_isvalid),
    .tl_dst           (tl_dst),
    .tl_pc            (tl_pc),
    .tl_r2            (tl_r2),
    .tl_data          (tl_data),
    .tl_isequal       (tl_isequal),
    .tl_mul           (tl_mul),
    .tl_flag_reg      (tl_flag_reg),
    .tl_flag_mul      (tl_flag_mul),
    .tl_flag_jump     (tl_flag_jump),
    .tl_flag_branch   (tl_flag_branch),
    .tl_flag_store    (tl_flag_store),
    .tl_flag_isbyte   (tl_flag_isbyte),
    .tl_flag_iret     (tl_flag_iret),
    .tl_flag_tlbwrite (tl_flag_tlbwrite),
    .rf_wen           (rf_wen),
    .rf_thread        (rf_thread),
    .rf_dst           (rf_dst),
    .rf_wdata         (rf_wdata),
    .redirect_en      (redirect_en),
    .redirect_thread  (redirect_thread),
    .redirect_pc      (redirect_pc),
    .store_en         (store_en),
    .store_isbyte     (store_isbyte),
    .store_addr       (store_addr),
    .store_data       (store_data),
    .store_ready      (store_ready),
    .sb_full          (sb_full)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one TL instruction for a single cycle, then return to an out-of-order idle pc.
  task automatic send(input threadid_t thr, input vptr_t pc, input logic valid,
                      input logic [5:0] fl, input logic iseq, input regid_t dst,
                      input word_t data, input word_t r2, input word_t mulv);
    tl_thread      = thr;
    tl_pc          = pc;
    tl_isvalid     = valid;
    tl_flag_reg    = fl[0];
    tl_flag_mul    = fl[1];
    tl_flag_jump   = fl[2];
    tl_flag_branch = fl[3];
    tl_flag_store  = fl[4];
    tl_flag_isbyte = fl[5];
    tl_isequal     = iseq;
    tl_dst         = dst;
    tl_data        = data;
    tl_r2          = r2;
    tl_mul         = mulv;
    tick();
    tl_pc      = IDLE_PC;
    tl_isvalid = 1'b0;
  endtask

  task automatic idle();
    tl_pc      = IDLE_PC;
    tl_isvalid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; store_ready = 1'b0;
    tl_thread = '0; tl_isvalid = 1'b0; tl_dst = '0; tl_pc = IDLE_PC;
    tl_r2 = '0; tl_data = '0; tl_mul = '0; tl_isequal = 1'b0;
    tl_flag_reg = 1'b0; tl_flag_mul = 1'b0; tl_flag_jump = 1'b0; tl_flag_branch = 1'b0;
    tl_flag_store = 1'b0; tl_flag_isbyte = 1'b0; tl_flag_iret = 1'b0;
    tl_flag_tlbwrite = TlbNone;
    tick(); tick();
    check_eq("rst_rf_wen", rf_wen, 0);
    check_eq("rst_redirect_en", redirect_en, 0);
    check_eq("rst_store_en", store_en, 0);
    check_eq("rst_sb_full", sb_full, 0);
    check_eq("rst_rf_wdata", rf_wdata, 0);
    check_eq("rst_redirect_pc", redirect_pc, 0);
    rst = 1'b0;

    // Register writeback on thread 2
    send(2, 32'h1000, 1, F_REG, 0, 5, 32'h55, 0, 0);
    check_eq("wb_rf_wen", rf_wen, 1);
    check_eq("wb_rf_thread", rf_thread, 2);
    check_eq("wb_rf_dst", rf_dst, 5);
    check_eq("wb_rf_wdata", rf_wdata, 32'h55);
    check_eq("wb_no_redirect", redirect_en, 0);
    idle();
    check_eq("wb_one_cycle", rf_wen, 0);
    send(2, 32'h1004, 0, 0, 0, 0, 0, 0, 0);
    check_eq("wb_probe_en", redirect_en, 1);
    check_eq("wb_probe_pc", redirect_pc, 32'h1004);
    check_eq("wb_probe_thr", redirect_thread, 2);
    send(2, 32'h1004, 1, F_REG | F_MUL, 0, 7, 32'h11, 0, 32'h77);
    check_eq("mul_rf_wen", rf_wen, 1);
    check_eq("mul_rf_dst", rf_dst, 7);
    check_eq("mul_rf_wdata", rf_wdata, 32'h77);

    // Taken branch on thread 0
    send(0, 32'h1000, 1, F_JMP | F_BR, 1, 0, 32'h2000, 0, 0);
    check_eq("br_redirect_en", redirect_en, 1);
    check_eq("br_redirect_thr", redirect_thread, 0);
    check_eq("br_redirect_pc", redirect_pc, 32'h2000);
    check_eq("br_no_rf", rf_wen, 0);
    idle();
    check_eq("br_one_cycle", redirect_en, 0);
    send(0, 32'h1004, 1, F_REG, 0, 3, 32'h99, 0, 0);
    check_eq("br_drop_rf", rf_wen, 0);
    check_eq("br_drop_redirect", redirect_en, 0);
    send(0, 32'h2000, 1, F_REG, 0, 3, 32'hAB, 0, 0);
    check_eq("br_target_rf_wen", rf_wen, 1);
    check_eq("br_target_wdata", rf_wdata, 32'hAB);
    send(0, 32'h2004, 1, F_REG | F_JMP | F_BR, 0, 4, 32'h3000, 0, 0);
    check_eq("nt_rf_wen", rf_wen, 1);
    check_eq("nt_wdata", rf_wdata, 32'h3000);
    check_eq("nt_no_redirect", redirect_en, 0);

    // Retry and out-of-order drop on thread 1
    send(1, 32'h1000, 0, F_REG, 0, 1, 32'h5, 0, 0);
    check_eq("retry_en", redirect_en, 1);
    check_eq("retry_thr", redirect_thread, 1);
    check_eq("retry_pc", redirect_pc, 32'h1000);
    check_eq("retry_no_rf", rf_wen, 0);
    send(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
    check_eq("retry_pc_kept", redirect_pc, 32'h1000);
    send(1, 32'h1008, 1, F_REG, 0, 1, 32'h5, 0, 0);
    check_eq("ooo_rf_wen", rf_wen, 0);
    check_eq("ooo_redirect", redirect_en, 0);
    send(1, 32'h1000, 1, F_REG, 0, 1, 32'h6, 0, 0);
    check_eq("retry_then_commit", rf_wen, 1);
    check_eq("retry_then_wdata", rf_wdata, 32'h6);

    // Fill the store buffer on thread 3 with the port stalled
    store_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_data[i] = 32'hABC0_0100 + 32'(i * 16);
      exp_r2[i]   = 32'h5000_0000 + 32'(i);
      send(3, 32'h1000 + 32'(i * 4), 1, (i % 2 == 1) ? (F_ST | F_BYTE) : F_ST, 0, 0,
           exp_data[i], exp_r2[i], 0);
      check_eq($sformatf("st%0d_no_redirect", i), redirect_en, 0);
      check_eq($sformatf("st%0d_store_en", i), store_en, 1);
    end
    check_eq("st_full", sb_full, 1);
    send(3, 32'h1010, 1, F_ST, 0, 0, 32'h0000_0777, 32'h7, 0);
    check_eq("st5_redirect_en", redirect_en, 1);
    check_eq("st5_redirect_pc", redirect_pc, 32'h1010);
    check_eq("st5_still_full", sb_full, 1);
    check_eq("head0_addr", store_addr, exp_data[0] & 32'h000F_FFFF);
    check_eq("head0_data", store_data, exp_r2[0]);
    check_eq("head0_isbyte", store_isbyte, 0);

    // Store arriving while full, in the same cycle as a pop, still retries
    store_ready = 1'b1;
    send(3, 32'h1010, 1, F_ST, 0, 0, 32'h0000_0777, 32'h7, 0);
    store_ready = 1'b0;
    check_eq("popfull_redirect_en", redirect_en, 1);
    check_eq("popfull_redirect_pc", redirect_pc, 32'h1010);
    check_eq("popfull_not_full", sb_full, 0);
    idle();
    store_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check_eq($sformatf("drain%0d_en", i), store_en, 1);
      check_eq($sformatf("drain%0d_addr", i), store_addr, exp_data[i] & 32'h000F_FFFF);
      check_eq($sformatf("drain%0d_data", i), store_data, exp_r2[i]);
      check_eq($sformatf("drain%0d_isbyte", i), store_isbyte, 32'(i % 2));
      idle();
    end
    check_eq("drained_empty", store_en, 0);

    // Simultaneous push and pop keeps one entry
    send(3, 32'h1010, 1, F_ST, 0, 0, 32'h000A_AAAA, 32'h1111, 0);
    check_eq("pp_first_en", store_en, 1);
    send(3, 32'h1014, 1, F_ST, 0, 0, 32'h000B_BBBB, 32'h2222, 0);
    check_eq("pp_en", store_en, 1);
    check_eq("pp_addr", store_addr, 32'h000B_BBBB);
    check_eq("pp_data", store_data, 32'h2222);
    idle();
    check_eq("pp_empty", store_en, 0);

    // Reset with three buffered stores
    store_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3, 32'h1018 + 32'(i * 4), 1, F_ST, 0, 0, 32'(i), 0, 0);
    check_eq("pre_rst_en", store_en, 1);
    rst = 1'b1;
    tl_thread = 3; tl_pc = 32'h1024; tl_isvalid = 1'b1; tl_flag_reg = 1'b1; tl_flag_store = 1'b0;
    tick();
    check_eq("rst2_store_en", store_en, 0);
    check_eq("rst2_sb_full", sb_full, 0);
    check_eq("rst2_rf_wen", rf_wen, 0);
    check_eq("rst2_redirect_en", redirect_en, 0);
    check_eq("rst2_rf_wdata", rf_wdata, 0);
    tl_isvalid = 1'b0; tl_flag_reg = 1'b0; tl_pc = IDLE_PC;
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      send(threadid_t'(t), 32'h1000, 0, 0, 0, 0, 0, 0, 0);
      check_eq($sformatf("rst2_pc_t%0d", t), redirect_pc, 32'h1000);
      check_eq($sformatf("rst2_probe_en_t%0d", t), redirect_en, 1);
    end
    idle();
    check_eq("rst2_still_empty", store_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/stage_wb.md
STAGE_WB -- requirements
Module: stage_wb

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, meaning store-buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h1000, meaning the per-thread commit PC after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have TL inputs: tl_thread threadid_t; tl_isvalid 1; tl_dst regid_t; tl_pc vptr_t; tl_r2 word_t; tl_data word_t; tl_isequal 1; tl_mul word_t.
REQ-006 SHALL have TL flag inputs, 1 bit each: tl_flag_reg, tl_flag_mul, tl_flag_jump, tl_flag_branch, tl_flag_store, tl_flag_isbyte, tl_flag_iret, plus tl_flag_tlbwrite of type tlbwrite_t.
REQ-007 SHALL have register-file write outputs: rf_wen 1; rf_thread threadid_t; rf_dst regid_t; rf_wdata word_t.
REQ-008 SHALL have redirect outputs: redirect_en 1; redirect_thread threadid_t; redirect_pc vptr_t (the new fetch PC for that thread).
REQ-009 SHALL have store port outputs store_en 1, store_isbyte 1, store_addr pptr_t (20 bits), store_data word_t, and input store_ready 1.
REQ-010 SHALL have output sb_full 1, asserted when the store buffer holds SB_DEPTH entries.

Function
REQ-011 SHALL keep a commit PC, waiting_pc[t], for each of the n_threads threads.
REQ-012 SHALL treat an incoming TL instruction as in-order only when tl_pc == waiting_pc[tl_thread]; any other instruction SHALL be dropped, with no output and no state change.
REQ-013 SHALL commit an in-order instruction when tl_isvalid=1 and NOT (tl_flag_store=1 AND sb_full=1).
REQ-014 SHALL, on commit, set waiting_pc to +4, wrapping modulo 2^32.
REQ-015 SHALL, on commit with tl_flag_reg=1, drive rf_wen=1 one cycle later, with rf_wdata = tl_mul if tl_flag_mul else tl_data, and rf_thread/rf_dst taken from the same instruction.
REQ-016 SHALL treat a jump as taken when tl_flag_jump AND (NOT tl_flag_branch OR tl_isequal).
REQ-017 SHALL, on a committed taken jump, set waiting_pc to tl_data (this overrides +4) and raise redirect_en with redirect_pc=tl_data one cycle later.
REQ-018 SHALL, on commit with tl_flag_store=1, push {tl_flag_isbyte, tl_data[19:0], tl_r2} into the store buffer.
REQ-019 SHALL, for an in-order instruction that does not commit (tl_isvalid=0, or a store arriving while sb_full), leave waiting_pc unchanged and raise redirect_en with redirect_pc=waiting_pc one cycle later (retry).
REQ-020 SHALL give tl_flag_iret and tl_flag_tlbwrite no side effect beyond a normal commit (reserved).
REQ-021 SHALL drive rf_wen and redirect_en for exactly one cycle per event, and zero otherwise.
REQ-022 SHALL run the store buffer as a FIFO: store_en=1 while it is non-empty, store_* showing the head entry, and a pop on store_en AND store_ready.
REQ-023 SHALL evaluate sb_full on the pre-pop occupancy, so a store arriving while full is retried even if a pop happens in the same cycle.
REQ-024 SHALL allow a push and a pop in the same cycle when the buffer is not full, with occupancy unchanged.
REQ-025 SHALL keep head and tail pointers wrapping modulo SB_DEPTH and the occupancy count log2(SB_DEPTH)+1 bits wide.

Reset
REQ-026 SHALL, while rst=1, set waiting_pc[all threads]=RESET_PC, empty the store buffer, and drive rf_wen=0, redirect_en=0, store_en=0 and sb_full=0.
REQ-027 SHALL, on rst asserted mid-operation, discard buffered stores without draining them; TL inputs SHALL be ignored during reset.
REQ-028 SHALL register all outputs except store_*, which come from the FIFO head; data outputs SHALL reset to 0.

Structure
REQ-029 SHALL take n_threads, threadid_t, word_t, vptr_t, pptr_t, regid_t and tlbwrite_t from package common; no new typedefs SHALL be added to it.
REQ-030 SHALL implement the FIFO as one sub-module, store_buffer, parameterised by SB_DEPTH.

Verification
REQ-031 SHALL test that thread 2, pc 0x1000, valid, flag_reg, dst 5, data 0x55 -> rf_wen for one cycle with thread 2, dst 5, wdata 0x55, and waiting_pc[2]=0x1004.
REQ-032 SHALL test that thread 0, pc 0x1000, flag_jump+flag_branch, isequal=1, data 0x2000 -> redirect thread 0 to pc 0x2000; then an instruction at pc 0x1004 is dropped and one at pc 0x2000 commits.
REQ-033 SHALL test that thread 1, in-order, isvalid=0 -> redirect_pc=0x1000 and waiting_pc unchanged; an out-of-order pc 0x1008 -> no outputs.
REQ-034 SHALL test that with store_ready held 0, five stores are issued: the first four commit, sb_full=1, and the fifth redirects to its own pc; then store_ready=1 drains the entries in order (addr = data[19:0]).
REQ-035 SHALL test that while full, a store issued in the same cycle as a pop is retried and occupancy becomes 3.
REQ-036 SHALL test that rst asserted with 3 buffered stores -> store_en=0 next cycle and waiting_pc for all threads = 0x1000.
